// File: rtl/apb_pkg.sv
// Shared types and constants for the two-requester APB master.
// Imported by the arbiter and the sequencing top.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  localparam int SEL_BIT     = 7;
  localparam int TIMEOUT_DEF = 15;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
// i_ptr names the requester that wins when both ask.
module rr_arbiter2
  import apb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    unique case (1'b1)
      (i_req == 2'b11): o_gnt = onehot2(i_ptr);
      (i_req == 2'b01): o_gnt = 2'b01;
      (i_req == 2'b10): o_gnt = 2'b10;
      default:          o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by two requesters: arbitrates, runs
// SETUP/ACCESS, bounds wait states and pulses a registered ACK.
module apb_arb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [1:0]  REQ,
  input  logic [1:0]  RWRITE,
  input  logic [15:0] RADDR,
  input  logic [15:0] RWDATA,
  output logic [1:0]  ACK,
  output logic [7:0]  RRDATA,
  output logic        RERR,
  output logic        PSEL1,
  output logic        PSEL2,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [7:0]  PADDR,
  output logic [7:0]  PWDATA,
  input  logic [7:0]  PRDATA1,
  input  logic [7:0]  PRDATA2,
  input  logic        PREADY
);

  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WW-1:0] LAST = WW'(TIMEOUT - 1);

  apb_state_t      r_state;
  apb_state_t      w_next;
  logic            r_ptr;
  logic            r_gidx;
  logic            r_write;
  logic [7:0]      r_addr;
  logic [7:0]      r_wdata;
  logic [WW-1:0]   r_wait;
  logic [1:0]      r_ack;
  logic [7:0]      r_rdata;
  logic            r_err;

  logic [1:0]      w_elig;
  logic [1:0]      w_gnt;
  logic            w_widx;
  logic            w_start;
  logic            w_done;
  logic            w_tout;
  logic [7:0]      w_prdata;
  logic [7:0]      w_raddr;
  logic [7:0]      w_rwdata;

  // The requester just acked is still holding REQ; skip it.
  assign w_elig = REQ & ~r_ack;

  rr_arbiter2 u_arb (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  assign w_widx   = w_gnt[1];
  assign w_raddr  = w_widx ? RADDR[15:8]  : RADDR[7:0];
  assign w_rwdata = w_widx ? RWDATA[15:8] : RWDATA[7:0];
  assign w_prdata = r_addr[SEL_BIT] ? PRDATA2 : PRDATA1;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_done  = 1'b0;
    w_tout  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (|w_gnt) begin
          w_next  = ST_SETUP;
          w_start = 1'b1;
        end
      end
      ST_SETUP: begin
        w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          w_next = ST_IDLE;
          w_done = 1'b1;
        end else if (r_wait == LAST) begin
          w_next = ST_IDLE;
          w_done = 1'b1;
          w_tout = 1'b1;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_ptr   <= 1'b0;
      r_gidx  <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wait  <= '0;
      r_ack   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_start) begin
        r_gidx  <= w_widx;
        r_ptr   <= ~w_widx;
        r_write <= RWRITE[w_widx];
        r_addr  <= w_raddr;
        r_wdata <= w_rwdata;
      end
      if (r_state == ST_ACCESS && !w_done) begin
        r_wait <= r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end
      r_ack   <= w_done ? onehot2(r_gidx) : 2'b00;
      r_err   <= w_tout;
      r_rdata <= (w_done && !w_tout && !r_write) ? w_prdata : 8'h00;
    end
  end

  assign PSEL1   = (r_state != ST_IDLE) && !r_addr[SEL_BIT];
  assign PSEL2   = (r_state != ST_IDLE) &&  r_addr[SEL_BIT];
  assign PENABLE = (r_state == ST_ACCESS);
  assign PWRITE  = r_write;
  assign PADDR   = r_addr;
  assign PWDATA  = r_wdata;
  assign ACK     = r_ack;
  assign RRDATA  = r_rdata;
  assign RERR    = r_err;

endmodule

// File: tb/tb_apb_arb_master.sv
// Randomised bench for apb_arb_master with a transaction-level
// model of arbitration order, bus timing and slave memory.
module tb_apb_arb_master;

  localparam int TO = 15;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [1:0]  REQ;
  logic [1:0]  RWRITE;
  logic [15:0] RADDR;
  logic [15:0] RWDATA;
  logic [1:0]  ACK;
  logic [7:0]  RRDATA;
  logic        RERR;
  logic        PSEL1;
  logic        PSEL2;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [7:0]  PWDATA;
  logic [7:0]  PRDATA1;
  logic [7:0]  PRDATA2;
  logic        PREADY;

  apb_arb_master #(.TIMEOUT(TO)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .REQ     (REQ),
    .RWRITE  (RWRITE),
    .RADDR   (RADDR),
    .RWDATA  (RWDATA),
    .ACK     (ACK),
    .RRDATA  (RRDATA),
    .RERR    (RERR),
    .PSEL1   (PSEL1),
    .PSEL2   (PSEL2),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA1 (PRDATA1),
    .PRDATA2 (PRDATA2),
    .PREADY  (PREADY)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
  } txn_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  txn_t q0[$];
  txn_t q1[$];
  int   wq[$];
  txn_t cur[2];
  bit   act[2];
  bit   gnt_r[2];
  bit   rl[2];
  bit   rand_on;
  logic [7:0] mem[256];

  // one transfer in flight: grant edge G, ACK cycle A
  bit   have;
  int   G, A, ka, who, wt, m_last;
  bit   e_err, e_w;
  logic [7:0] e_a, e_d, e_rd;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.w = 1'($urandom_range(1));
    t.a = {1'($urandom_range(1)), 4'b0000, 3'($urandom_range(7))};
    t.d = 8'($urandom);
    return t;
  endfunction

  task automatic m_reset();
    have   = 0;
    m_last = 1;
    G      = -10;
    A      = -10;
    for (int r = 0; r < 2; r++) begin
      act[r]   = 0;
      gnt_r[r] = 0;
      rl[r]    = 0;
    end
  endtask

  // One cycle: check outputs, drive requesters and slave, model the edge.
  task automatic step();
    bit live, acc, rdy, ackc;
    logic [1:0] el;
    int w;
    live = have && cyc >= G && cyc <= G + ka;
    acc  = live && cyc > G;
    ackc = have && cyc == A;
    chk("psel1", 16'(PSEL1), 16'(live && !e_a[7]));
    chk("psel2", 16'(PSEL2), 16'(live && e_a[7]));
    chk("penable", 16'(PENABLE), 16'(acc));
    if (live) begin
      chk("paddr", 16'(PADDR), 16'(e_a));
      chk("pwrite", 16'(PWRITE), 16'(e_w));
      chk("pwdata", 16'(PWDATA), 16'(e_d));
    end
    if (ackc) begin
      chk("ack", 16'(ACK), 16'(2'b01 << who));
      chk("rerr", 16'(RERR), 16'(e_err));
      chk("rrdata", 16'(RRDATA), 16'(e_rd));
      if (!e_err && e_w) mem[e_a] = e_d;
    end else begin
      chk("ack_idle", 16'(ACK), 16'h0);
      chk("rrdata_idle", 16'(RRDATA), 16'h0);
    end

    for (int r = 0; r < 2; r++) begin
      if (ackc && who == r) begin
        act[r]   = 0;
        gnt_r[r] = 0;
      end
      if (act[r] && !gnt_r[r] && rand_on && $urandom_range(7) == 0)
        act[r] = 0;
      if (!act[r]) begin
        if (r == 0 && q0.size() > 0) begin
          cur[0] = q0.pop_front();
          act[0] = 1;
        end else if (r == 1 && q1.size() > 0) begin
          cur[1] = q1.pop_front();
          act[1] = 1;
        end else if (rand_on && $urandom_range(1) == 1) begin
          cur[r] = rand_txn();
          act[r] = 1;
        end
      end
      rl[r] = act[r] && (!gnt_r[r] || !rand_on ||
                         $urandom_range(1) == 1);
    end
    REQ    = {rl[1], rl[0]};
    RWRITE = {cur[1].w, cur[0].w};
    RADDR  = {cur[1].a, cur[0].a};
    RWDATA = {cur[1].d, cur[0].d};

    rdy     = acc && !e_err && cyc == G + wt + 1;
    PREADY  = acc ? rdy : 1'($urandom_range(1));
    PRDATA1 = 8'($urandom);
    PRDATA2 = 8'($urandom);
    if (rdy && !e_w) begin
      if (e_a[7]) PRDATA2 = e_rd;
      else        PRDATA1 = e_rd;
    end

    if (!have || cyc >= A) begin
      el = {rl[1] && !gnt_r[1], rl[0] && !gnt_r[0]};
      if (ackc) el[who] = 1'b0;
      if (el != 2'b00) begin
        w = (el == 2'b11) ? (m_last == 1 ? 0 : 1) : (el[1] ? 1 : 0);
        m_last   = w;
        gnt_r[w] = 1;
        have     = 1;
        who      = w;
        G        = cyc + 1;
        if (wq.size() > 0) wt = wq.pop_front();
        else wt = ($urandom_range(9) == 0) ? TO + 3 : $urandom_range(3);
        e_err = (wt >= TO);
        ka    = e_err ? TO : wt + 1;
        A     = G + ka + 1;
        e_w   = cur[w].w;
        e_a   = cur[w].a;
        e_d   = cur[w].d;
        e_rd  = (e_err || e_w) ? 8'h00 : mem[e_a];
      end
    end
    @(negedge PCLK);
    cyc++;
  endtask

  task automatic drain(input string tag);
    rand_on = 0;
    for (int i = 0; i < 200 && (act[0] || act[1] || (have && cyc <= A)); i++)
      step();
    chk(tag, 16'(act[0] || act[1] || (have && cyc <= A)), 16'h0);
  endtask

  initial begin
    PRESET  = 1'b1;
    REQ     = '0;
    RWRITE  = '0;
    RADDR   = '0;
    RWDATA  = '0;
    PRDATA1 = '0;
    PRDATA2 = '0;
    PREADY  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    cur[0] = '0;
    cur[1] = '0;
    m_reset();
    e_a = '0;
    e_d = '0;
    e_w = 0;
    e_err = 0;
    e_rd = '0;
    who = 0;
    wt = 0;
    ka = 0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_ack", 16'(ACK), 16'h0);
    chk("rst_sel", 16'({PSEL2, PSEL1, PENABLE}), 16'h0);
    chk("rst_bus", 16'({PADDR, PWDATA}), 16'h0);
    chk("rst_misc", 16'({PWRITE, RERR, RRDATA}), 16'h0);
    PRESET = 1'b0;

    // write/readback, PSEL2 decode, wait-limit boundary, timeout
    rand_on = 0;
    q0.push_back('{1'b1, 8'h05, 8'hA5});
    q0.push_back('{1'b0, 8'h85, 8'h00});
    q0.push_back('{1'b1, 8'h20, 8'h33});
    q1.push_back('{1'b0, 8'h05, 8'h00});
    q1.push_back('{1'b1, 8'h85, 8'h5A});
    q1.push_back('{1'b0, 8'h20, 8'h00});
    wq = '{0, 0, 0, 2, TO - 1, TO};
    drain("drain_dir");

    rand_on = 1;
    repeat (800) step();
    drain("drain_rand");

    // abort a transfer with reset in the middle of its wait states
    q0.push_back('{1'b0, 8'h12, 8'h00});
    wq.push_back(TO + 5);
    for (int i = 0; i < 30 && !(have && cyc == G + 3); i++) step();
    chk("rst_reach", 16'(have && cyc == G + 3), 16'h1);
    #2 PRESET = 1'b1;
    #1;
    chk("arst_sel", 16'({PSEL2, PSEL1, PENABLE}), 16'h0);
    chk("arst_ack", 16'(ACK), 16'h0);
    REQ = '0;
    @(posedge PCLK);
    #1;
    chk("arst_hold", 16'({ACK, PSEL1, PENABLE}), 16'h0);
    @(negedge PCLK);
    PRESET = 1'b0;
    m_reset();
    q0 = {};
    q1 = {};
    wq = {};
    q1.push_back('{1'b1, 8'h12, 8'h77});
    q0.push_back('{1'b0, 8'h12, 8'h00});
    wq = '{1, 0};
    drain("drain_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum ACCESS-phase cycles allowed without PREADY.
REQ-002 SHALL have port PCLK, input, 1: single clock, all state updates on its rising edge.
REQ-003 SHALL have port PRESET, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port REQ, input, 2: per-requester transfer request, held high until its ACK.
REQ-005 SHALL have port RWRITE, input, 2: per-requester direction, 1 = write.
REQ-006 SHALL have port RADDR, input, 16: {requester1 addr[7:0], requester0 addr[7:0]}.
REQ-007 SHALL have port RWDATA, input, 16: {requester1 wdata[7:0], requester0 wdata[7:0]}.
REQ-008 SHALL have port ACK, output, 2: one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port RRDATA, output, 8: read data, valid while ACK is high.
REQ-010 SHALL have port RERR, output, 1: timeout flag, valid while ACK is high.
REQ-011 SHALL have ports PSEL1 and PSEL2, output, 1 each: APB slave selects.
REQ-012 SHALL have ports PENABLE and PWRITE, output, 1 each: APB phase and direction.
REQ-013 SHALL have ports PADDR and PWDATA, output, 8 each: APB address and write data.
REQ-014 SHALL have ports PRDATA1 and PRDATA2, input, 8 each; and PREADY, input, 1.

Function
REQ-015 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE; SETUP lasts exactly one cycle.
REQ-016 In IDLE, with any eligible REQ high, SHALL grant one requester using round-robin arbitration: the requester not granted last wins ties.
REQ-017 On grant, SHALL register the winner's RWRITE, RADDR and RWDATA; PADDR, PWRITE and PWDATA SHALL stay stable through SETUP and ACCESS.
REQ-018 Slave decode SHALL be PADDR[7]=0 -> PSEL1 and PADDR[7]=1 -> PSEL2; exactly one PSEL is high in SETUP and ACCESS, and none is high in IDLE.
REQ-019 PENABLE SHALL be 0 in SETUP and 1 in ACCESS.
REQ-020 In ACCESS with PREADY=1, SHALL capture the selected PRDATA (reads; writes capture 0) and return to IDLE.
REQ-021 ACK[granted], RRDATA and RERR SHALL be registered and asserted in the cycle after ACCESS ends; RRDATA SHALL be 0 when ACK is low.
REQ-022 During the ACK cycle, SHALL ignore REQ of the acked requester; the other requester may be granted in that same cycle.
REQ-023 Minimum latency SHALL be: REQ sampled in IDLE at edge n -> SETUP in cycle n+1 -> ACCESS in cycle n+2 -> ACK in cycle n+3 (zero wait states).
REQ-024 A wait counter SHALL count ACCESS cycles with PREADY=0; on reaching TIMEOUT, SHALL end the transfer with ACK, RERR=1 and RRDATA=0.
REQ-025 A REQ deasserted before grant SHALL be dropped silently; once granted, a transfer SHALL complete regardless of REQ.

Reset
REQ-026 PRESET high SHALL asynchronously force state IDLE, all outputs 0, wait counter 0, and the round-robin pointer to favour requester0.
REQ-027 Reset during SETUP or ACCESS SHALL abort the transfer with no ACK; operation SHALL resume from IDLE on the first edge after release.

Structure
REQ-028 A shared package apb_pkg SHALL hold the FSM state typedef, the decode bit index (7), and the TIMEOUT default.
REQ-029 Arbitration SHALL be a sub-module rr_arbiter2 (REQ, pointer -> one-hot grant); the APB sequencing SHALL remain in apb_arb_master.

Verification
REQ-030 Single write: req0 write addr 0x05 data 0xA5, with PREADY tied to PSEL&PENABLE -> PSEL1 for 2 cycles, PENABLE in cycle 2, ACK[0] at n+3, RERR=0.
REQ-031 Readback: req1 read addr 0x05 after REQ-030 -> RRDATA=0xA5 with ACK[1] at n+3.
REQ-032 Contention: REQ=2'b11 continuously, four transfers -> grants alternate 0,1,0,1 with no IDLE gap after each ACK.
REQ-033 Decode: req0 addr 0x85 -> PSEL2 high, PSEL1 never high, RRDATA taken from PRDATA2.
REQ-034 Timeout: PREADY held 0 with TIMEOUT=15 -> 15 ACCESS cycles, then ACK with RERR=1 and RRDATA=0.
REQ-035 Reset mid-ACCESS: assert PRESET during a wait state -> outputs 0 asynchronously, no ACK; the next request completes normally.
